dual_port_ram_be: RTL and testbench

Single-clock true dual-port RAM with per-byte write enables and a selectable read-during-write policy. Also provides:
- deterministic cross-port collision resolution and a collision flag;
- an optional output register stage;
- a post-reset clear engine that zeroes the whole array before ports are accepted.

It is the general buffer used by the UDP/Ethernet datapath for packet and descriptor storage.

---
 rtl/dpram_pkg.sv | 32 +++
 rtl/dual_port_ram_be_clear.sv | 48 ++++
 rtl/dual_port_ram_be.sv | 145 ++++++++++++++
 tb/tb_dual_port_ram_be.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// Shared types and the lane-merge helper for the byte-enable dual-port RAM.
// Pure declarations: no latency, no flow control.
package dpram_pkg;

    typedef enum logic {RDW_NEW = 1'b0, RDW_OLD = 1'b1} rdw_mode_e;
    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} clr_state_e;

    // Widest word/lane count the merge helper handles; callers zero-extend into it.
    localparam int MERGE_W  = 1024;
    localparam int MERGE_NB = 1024;

    // Take nw_w on every lane whose enable is set, old_w elsewhere.
    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0]  old_w,
        input logic [MERGE_W-1:0]  nw_w,
        input logic [MERGE_NB-1:0] we,
        input int                  nb,
        input int                  bw
    );
        logic [MERGE_W-1:0] r;
        int lane;
        r = old_w;
        for (int b = 0; b < MERGE_W; b++) begin
            lane = b / bw;
            if (lane < nb && we[lane]) begin
                r[b] = nw_w[b];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dual_port_ram_be_clear.sv
// Post-reset sweep that zeroes one word per cycle, then raises init_done.
// 2**ADDR_WIDTH+1 cycles from reset release to init_done; no backpressure, ports are simply locked out.
module dpram_clear_fsm
    import dpram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  clr_active,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  init_done
);

    localparam clr_state_e RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RST_STATE;
            addr_q    <= '0;
            init_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            // Lags READY by one edge so the last cleared word is settled first.
            init_done <= (state_q == READY);
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        if (state_q == CLEAR) begin
            addr_d = addr_q + 1'b1;
            if (addr_q == {ADDR_WIDTH{1'b1}}) begin
                state_d = READY;
            end
        end
    end

    assign clr_active = (state_q == CLEAR);
    assign clr_addr   = addr_q;

endmodule

// File: rtl/dual_port_ram_be.sv
// True dual-port byte-enable RAM with A-wins collision merge and selectable read-during-write.
// Read latency 1+OUT_REG; no backpressure, every accepted request returns a valid.
module dual_port_ram_be
    import dpram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int OUT_REG        = 0,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1,
    localparam int NB            = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  init_done,
    input  logic                  en_a,
    input  logic [NB-1:0]         we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] q_a,
    output logic                  valid_a,
    input  logic                  en_b,
    input  logic [NB-1:0]         we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    output logic [DATA_WIDTH-1:0] q_b,
    output logic                  valid_b,
    output logic                  collision
);

    localparam int        DEPTH   = 2 ** ADDR_WIDTH;
    localparam rdw_mode_e RDW_POL = (RDW_MODE != 0) ? RDW_OLD : RDW_NEW;

    function automatic logic [DATA_WIDTH-1:0] lane_merge(
        input logic [DATA_WIDTH-1:0] o,
        input logic [DATA_WIDTH-1:0] n,
        input logic [NB-1:0]         w
    );
        logic [MERGE_W-1:0]  oe, ne;
        logic [MERGE_NB-1:0] we_e;
        oe = '0;
        ne = '0;
        we_e = '0;
        oe[DATA_WIDTH-1:0] = o;
        ne[DATA_WIDTH-1:0] = n;
        we_e[NB-1:0] = w;
        return DATA_WIDTH'(byte_merge(oe, ne, we_e, NB, BYTE_WIDTH));
    endfunction

    logic                  clr_active;
    logic [ADDR_WIDTH-1:0] clr_addr;

    dpram_clear_fsm #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr_active (clr_active),
        .clr_addr   (clr_addr),
        .init_done  (init_done)
    );

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic                  acc_a, acc_b, wr_a, wr_b, same, coll;
    logic [DATA_WIDTH-1:0] old_a, old_b, word_a, word_b, final_a, final_b, rd_a, rd_b;

    always_comb begin
        old_a  = mem[addr_a];
        old_b  = mem[addr_b];
        acc_a  = en_a & init_done;
        acc_b  = en_b & init_done;
        wr_a   = acc_a & (|we_a);
        wr_b   = acc_b & (|we_b);
        same   = acc_a & acc_b & (addr_a == addr_b);
        coll   = same & (wr_a | wr_b);
        word_b = lane_merge(old_b, data_b, we_b);
        // On a double write A is layered over B's result, so A owns shared lanes.
        word_a = lane_merge((same && wr_b) ? word_b : old_a, data_a, we_a);
        final_a = wr_a ? word_a : ((same && wr_b) ? word_b : old_a);
        final_b = (same && wr_a) ? word_a : (wr_b ? word_b : old_b);
        rd_a    = (RDW_POL == RDW_OLD) ? old_a : final_a;
        rd_b    = (RDW_POL == RDW_OLD) ? old_b : final_b;
    end

    always_ff @(posedge clk) begin
        if (clr_active) begin
            mem[clr_addr] <= '0;
        end else begin
            if (wr_b) mem[addr_b] <= word_b;
            if (wr_a) mem[addr_a] <= word_a;
        end
    end

    logic [DATA_WIDTH-1:0] q1_a, q1_b;
    logic                  v1_a, v1_b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q1_a      <= '0;
            q1_b      <= '0;
            v1_a      <= 1'b0;
            v1_b      <= 1'b0;
            collision <= 1'b0;
        end else begin
            if (acc_a) q1_a <= rd_a;
            if (acc_b) q1_b <= rd_b;
            v1_a      <= acc_a;
            v1_b      <= acc_b;
            collision <= coll;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] q2_a, q2_b;
            logic                  v2_a, v2_b;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    q2_a <= '0;
                    q2_b <= '0;
                    v2_a <= 1'b0;
                    v2_b <= 1'b0;
                end else begin
                    q2_a <= q1_a;
                    q2_b <= q1_b;
                    v2_a <= v1_a;
                    v2_b <= v1_b;
                end
            end
            assign q_a     = q2_a;
            assign q_b     = q2_b;
            assign valid_a = v2_a;
            assign valid_b = v2_b;
        end else begin : g_no_out_reg
            assign q_a     = q1_a;
            assign q_b     = q1_b;
            assign valid_a = v1_a;
            assign valid_b = v1_b;
        end
    endgenerate

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Directed bench: dut0 = (OUT_REG 0, NEW), dut1 = (OUT_REG 1, OLD), both 16 words, shared stimulus.
module tb_dual_port_ram_be;

    logic        clk;
    logic        reset_n;
    logic        en_a, en_b;
    logic [3:0]  we_a, we_b;
    logic [3:0]  addr_a, addr_b;
    logic [31:0] data_a, data_b;

    logic [31:0] d0_q_a, d0_q_b, d1_q_a, d1_q_b;
    logic        d0_valid_a, d0_valid_b, d1_valid_a, d1_valid_b;
    logic        d0_coll, d1_coll, d0_init, d1_init;

    int vectors = 0;
    int miscompares = 0;

    dual_port_ram_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4),
                       .OUT_REG(0), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .init_done(d0_init),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a),
        .q_a(d0_q_a), .valid_a(d0_valid_a),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b),
        .q_b(d0_q_b), .valid_b(d0_valid_b), .collision(d0_coll));

    dual_port_ram_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4),
                       .OUT_REG(1), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .init_done(d1_init),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a),
        .q_a(d1_q_a), .valid_a(d1_valid_a),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b),
        .q_b(d1_q_b), .valid_b(d1_valid_b), .collision(d1_coll));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en_a = 1'b0; en_b = 1'b0; we_a = 4'h0; we_b = 4'h0;
    endtask

    task automatic drive_a(input logic [3:0] ad, input logic [3:0] we, input logic [31:0] d);
        en_a = 1'b1; addr_a = ad; we_a = we; data_a = d;
    endtask

    task automatic drive_b(input logic [3:0] ad, input logic [3:0] we, input logic [31:0] d);
        en_b = 1'b1; addr_b = ad; we_b = we; data_b = d;
    endtask

    // Counts edges after reset release until init_done; -1 if the bound expires.
    task automatic wait_init(output int cyc, output bit vbad);
        cyc = -1;
        vbad = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            step();
            if (d0_valid_a || d1_valid_a || d0_valid_b || d1_valid_b) vbad = 1'b1;
            if (d0_init && d1_init) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int cyc;
        bit vbad;
        reset_n = 1'b0;
        idle();
        addr_a = 4'h0; addr_b = 4'h0; data_a = '0; data_b = '0;
        step();
        step();
        vectors++;
        if ({d0_init, d0_valid_a, d0_valid_b, d0_coll, d1_init, d1_valid_a, d1_valid_b, d1_coll} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 00000000",
                     {d0_init, d0_valid_a, d0_valid_b, d0_coll, d1_init, d1_valid_a, d1_valid_b, d1_coll});
        end
        vectors++;
        if ({d0_q_a, d0_q_b, d1_q_a, d1_q_b} !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_q: got %h %h %h %h want 0", d0_q_a, d0_q_b, d1_q_a, d1_q_b);
        end
        reset_n = 1'b1;
        wait_init(cyc, vbad);
        vectors++;
        if (cyc !== 17) begin
            miscompares++;
            $display("FAIL first_init_cycles: got %0d want 17", cyc);
        end
    endtask

    task automatic test_clear();
        int cyc;
        bit vbad;
        drive_a(4'd3, 4'hF, 32'hDEADBEEF);
        step();
        drive_a(4'd3, 4'h0, 32'h0);
        step();
        idle();
        vectors++;
        if (d0_valid_a !== 1'b1 || d0_q_a !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL preload_read: got v=%b q=%h want v=1 q=deadbeef", d0_valid_a, d0_q_a);
        end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        drive_a(4'd3, 4'h0, 32'h0);
        wait_init(cyc, vbad);
        vectors++;
        if (cyc !== 17) begin
            miscompares++;
            $display("FAIL clear_init_cycles: got %0d want 17", cyc);
        end
        vectors++;
        if (vbad !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_ignores_en: got valid during clear=%b want 0", vbad);
        end
        step();
        vectors++;
        if (d0_valid_a !== 1'b1 || d0_q_a !== 32'h0) begin
            miscompares++;
            $display("FAIL cleared_word_d0: got v=%b q=%h want v=1 q=00000000", d0_valid_a, d0_q_a);
        end
        idle();
        step();
        vectors++;
        if (d1_valid_a !== 1'b1 || d1_q_a !== 32'h0) begin
            miscompares++;
            $display("FAIL cleared_word_d1: got v=%b q=%h want v=1 q=00000000", d1_valid_a, d1_q_a);
        end
        step();
    endtask

    task automatic test_byte_enable();
        drive_a(4'd5, 4'hF, 32'h11223344);
        step();
        drive_a(4'd5, 4'b0101, 32'hAABBCCDD);
        step();
        idle();
        step();
        step();
        drive_a(4'd5, 4'h0, 32'h0);
        step();
        idle();
        vectors++;
        if (d0_valid_a !== 1'b1 || d0_q_a !== 32'h11BB33DD || d1_valid_a !== 1'b0) begin
            miscompares++;
            $display("FAIL be_lat1: got d0 v=%b q=%h d1 v=%b want d0 v=1 q=11bb33dd d1 v=0",
                     d0_valid_a, d0_q_a, d1_valid_a);
        end
        step();
        vectors++;
        if (d1_valid_a !== 1'b1 || d1_q_a !== 32'h11BB33DD || d0_valid_a !== 1'b0 || d0_q_a !== 32'h11BB33DD) begin
            miscompares++;
            $display("FAIL be_lat2: got d1 v=%b q=%h d0 v=%b q=%h want d1 v=1 q=11bb33dd d0 v=0 q=11bb33dd",
                     d1_valid_a, d1_q_a, d0_valid_a, d0_q_a);
        end
        step();
    endtask

    task automatic test_rdw();
        drive_a(4'd7, 4'hF, 32'h00000001);
        step();
        idle();
        step();
        step();
        drive_a(4'd7, 4'hF, 32'h00000002);
        step();
        idle();
        vectors++;
        if (d0_valid_a !== 1'b1 || d0_q_a !== 32'h00000002) begin
            miscompares++;
            $display("FAIL rdw_new: got v=%b q=%h want v=1 q=00000002", d0_valid_a, d0_q_a);
        end
        step();
        vectors++;
        if (d1_valid_a !== 1'b1 || d1_q_a !== 32'h00000001) begin
            miscompares++;
            $display("FAIL rdw_old: got v=%b q=%h want v=1 q=00000001", d1_valid_a, d1_q_a);
        end
        step();
    endtask

    task automatic test_dual_write();
        drive_a(4'd9, 4'b0011, 32'hAAAAAAAA);
        drive_b(4'd9, 4'b0110, 32'hBBBBBBBB);
        step();
        idle();
        vectors++;
        if (d0_coll !== 1'b1 || d1_coll !== 1'b1) begin
            miscompares++;
            $display("FAIL ww_coll_pulse: got %b %b want 1 1", d0_coll, d1_coll);
        end
        vectors++;
        if (d0_q_a !== 32'h00BBAAAA || d0_q_b !== 32'h00BBAAAA) begin
            miscompares++;
            $display("FAIL ww_new_q: got a=%h b=%h want 00bbaaaa", d0_q_a, d0_q_b);
        end
        step();
        vectors++;
        if (d0_coll !== 1'b0 || d1_coll !== 1'b0) begin
            miscompares++;
            $display("FAIL ww_coll_one_cycle: got %b %b want 0 0", d0_coll, d1_coll);
        end
        vectors++;
        if (d1_valid_a !== 1'b1 || d1_q_a !== 32'h0 || d1_q_b !== 32'h0) begin
            miscompares++;
            $display("FAIL ww_old_q: got v=%b a=%h b=%h want v=1 0 0", d1_valid_a, d1_q_a, d1_q_b);
        end
        drive_a(4'd9, 4'h0, 32'h0);
        drive_b(4'd9, 4'h0, 32'h0);
        step();
        idle();
        vectors++;
        if (d0_coll !== 1'b0 || d0_q_a !== 32'h00BBAAAA || d0_q_b !== 32'h00BBAAAA) begin
            miscompares++;
            $display("FAIL rr_same_addr: got coll=%b a=%h b=%h want coll=0 00bbaaaa", d0_coll, d0_q_a, d0_q_b);
        end
        step();
        vectors++;
        if (d1_coll !== 1'b0 || d1_q_a !== 32'h00BBAAAA || d1_q_b !== 32'h00BBAAAA) begin
            miscompares++;
            $display("FAIL rr_stored_d1: got coll=%b a=%h b=%h want coll=0 00bbaaaa", d1_coll, d1_q_a, d1_q_b);
        end
        step();
    endtask

    task automatic test_wr_rd_collision();
        drive_a(4'd10, 4'hF, 32'h12345678);
        step();
        idle();
        step();
        step();
        drive_a(4'd10, 4'b1000, 32'hFF000000);
        drive_b(4'd10, 4'h0, 32'h0);
        step();
        idle();
        vectors++;
        if (d0_coll !== 1'b1 || d0_valid_b !== 1'b1 || d0_q_b !== 32'hFF345678) begin
            miscompares++;
            $display("FAIL wr_rd_new: got coll=%b v=%b q_b=%h want coll=1 v=1 q_b=ff345678",
                     d0_coll, d0_valid_b, d0_q_b);
        end
        step();
        vectors++;
        if (d1_coll !== 1'b0 || d1_valid_b !== 1'b1 || d1_q_b !== 32'h12345678) begin
            miscompares++;
            $display("FAIL wr_rd_old: got coll=%b v=%b q_b=%h want coll=0 v=1 q_b=12345678",
                     d1_coll, d1_valid_b, d1_q_b);
        end
        step();
    endtask

    task automatic test_back_to_back();
        drive_a(4'd5, 4'h0, 32'h0);
        step();
        drive_a(4'd7, 4'h0, 32'h0);
        step();
        idle();
        vectors++;
        if (d0_valid_a !== 1'b1 || d0_q_a !== 32'h00000002 || d1_valid_a !== 1'b1 || d1_q_a !== 32'h11BB33DD) begin
            miscompares++;
            $display("FAIL b2b_first: got d0 v=%b q=%h d1 v=%b q=%h want 1 00000002 1 11bb33dd",
                     d0_valid_a, d0_q_a, d1_valid_a, d1_q_a);
        end
        step();
        vectors++;
        if (d1_valid_a !== 1'b1 || d1_q_a !== 32'h00000002 || d0_valid_a !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_second: got d1 v=%b q=%h d0 v=%b want 1 00000002 0",
                     d1_valid_a, d1_q_a, d0_valid_a);
        end
        step();
    endtask

    task automatic test_reset_mid_read();
        int cyc;
        bit vbad;
        drive_a(4'd5, 4'h0, 32'h0);
        step();
        idle();
        reset_n = 1'b0;
        #1;
        vectors++;
        if (d1_valid_a !== 1'b0 || d1_q_a !== 32'h0 || d1_init !== 1'b0) begin
            miscompares++;
            $display("FAIL midread_drop: got v=%b q=%h init=%b want 0 0 0", d1_valid_a, d1_q_a, d1_init);
        end
        step();
        reset_n = 1'b1;
        drive_a(4'd5, 4'h0, 32'h0);
        wait_init(cyc, vbad);
        idle();
        vectors++;
        if (cyc !== 17 || vbad !== 1'b0) begin
            miscompares++;
            $display("FAIL midread_restart: got cycles=%0d valid_seen=%b want 17 0", cyc, vbad);
        end
        drive_a(4'd5, 4'h0, 32'h0);
        step();
        idle();
        step();
        vectors++;
        if (d1_valid_a !== 1'b1 || d1_q_a !== 32'h0) begin
            miscompares++;
            $display("FAIL midread_recleared: got v=%b q=%h want 1 00000000", d1_valid_a, d1_q_a);
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_byte_enable();
        test_rdw();
        test_dual_write();
        test_wr_rd_collision();
        test_back_to_back();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
